// File: rtl/fp_toplama.sv
// fp_toplama: multi-cycle IEEE-754 single-precision adder/subtractor.
// Optional round-to-nearest-even in YUVARLA when FP_TOPLAMA_YUVARLAMA_EN is defined.
module fp_toplama (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        gecerli_i,
    input  logic [31:0] x1_i,
    input  logic [31:0] x2_i,
    output logic        hazir_o,
    output logic [31:0] sonuc_o,
    output logic        gecerli_o
);

    typedef enum logic [2:0] {
        BOSTA,
        AYIR,
        HIZALA,
        TOPLA,
        NORMAL,
        YUVARLA,
        PAKETLE
    } durum_e;

    durum_e             durum_q, durum_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               isaret_q, isaret_d;
    logic               cikar_q, cikar_d;
    logic               atla_q, atla_d;
    logic signed [9:0]  us_q, us_d;
    logic [27:0]        mb_q, mb_d;
    logic [27:0]        mk_q, mk_d;
    logic [4:0]         sayac_q, sayac_d;
    logic [31:0]        sonuc_q, sonuc_d;
    logic               gecerli_q, gecerli_d;

    logic               a_sifir;
    logic               b_sifir;
    logic               takas;
    logic [31:0]        buyuk;
    logic [31:0]        kucuk;
    logic [7:0]         fark;
    logic [27:0]        toplam;

    assign a_sifir = (a_q[30:23] == 8'd0);
    assign b_sifir = (b_q[30:23] == 8'd0);
    assign takas   = (b_q[30:0] > a_q[30:0]);
    assign buyuk   = takas ? b_q : a_q;
    assign kucuk   = takas ? a_q : b_q;
    assign fark    = buyuk[30:23] - kucuk[30:23];
    assign toplam  = cikar_q ? (mb_q - mk_q) : (mb_q + mk_q);

`ifdef FP_TOPLAMA_YUVARLAMA_EN
    logic               yuv_art;
    logic [27:0]        yuv_m;

    assign yuv_art = mb_q[2] & (mb_q[1] | mb_q[0] | mb_q[3]);
    assign yuv_m   = mb_q + {24'd0, yuv_art, 3'b000};
`endif

    assign hazir_o   = (durum_q == BOSTA);
    assign sonuc_o   = sonuc_q;
    assign gecerli_o = gecerli_q;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q   <= BOSTA;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            isaret_q  <= 1'b0;
            cikar_q   <= 1'b0;
            atla_q    <= 1'b0;
            us_q      <= 10'sd0;
            mb_q      <= 28'd0;
            mk_q      <= 28'd0;
            sayac_q   <= 5'd0;
            sonuc_q   <= 32'd0;
            gecerli_q <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            a_q       <= a_d;
            b_q       <= b_d;
            isaret_q  <= isaret_d;
            cikar_q   <= cikar_d;
            atla_q    <= atla_d;
            us_q      <= us_d;
            mb_q      <= mb_d;
            mk_q      <= mk_d;
            sayac_q   <= sayac_d;
            sonuc_q   <= sonuc_d;
            gecerli_q <= gecerli_d;
        end
    end

    // Next-state and datapath: one alignment or normalisation shift per cycle
    always_comb begin
        durum_d   = durum_q;
        a_d       = a_q;
        b_d       = b_q;
        isaret_d  = isaret_q;
        cikar_d   = cikar_q;
        atla_d    = atla_q;
        us_d      = us_q;
        mb_d      = mb_q;
        mk_d      = mk_q;
        sayac_d   = sayac_q;
        sonuc_d   = sonuc_q;
        gecerli_d = 1'b0;

        unique case (durum_q)
            BOSTA: begin
                if (gecerli_i) begin
                    a_d     = x1_i;
                    b_d     = x2_i;
                    atla_d  = 1'b0;
                    durum_d = AYIR;
                end
            end

            AYIR: begin
                if (a_sifir || b_sifir) begin
                    // Zero operand: the other one passes through unchanged
                    atla_d  = 1'b1;
                    durum_d = PAKETLE;
                    if (a_sifir && b_sifir) begin
                        a_d = {a_q[31] & b_q[31], 31'd0};
                    end else if (a_sifir) begin
                        a_d = b_q;
                    end
                end else begin
                    isaret_d = buyuk[31];
                    cikar_d  = buyuk[31] ^ kucuk[31];
                    us_d     = {2'b00, buyuk[30:23]};
                    mb_d     = {2'b01, buyuk[22:0], 3'b000};
                    mk_d     = {2'b01, kucuk[22:0], 3'b000};
                    sayac_d  = (fark > 8'd27) ? 5'd27 : fark[4:0];
                    durum_d  = (fark == 8'd0) ? TOPLA : HIZALA;
                end
            end

            HIZALA: begin
                mk_d    = {1'b0, mk_q[27:2], mk_q[1] | mk_q[0]};
                sayac_d = sayac_q - 5'd1;
                if (sayac_q == 5'd1) begin
                    durum_d = TOPLA;
                end
            end

            TOPLA: begin
                if (toplam == 28'd0) begin
                    isaret_d = 1'b0;
                    us_d     = 10'sd0;
                    mb_d     = 28'd0;
                    durum_d  = PAKETLE;
                end else begin
                    mb_d    = toplam;
                    durum_d = NORMAL;
                end
            end

            NORMAL: begin
                if (mb_q[27]) begin
                    mb_d    = {1'b0, mb_q[27:2], mb_q[1] | mb_q[0]};
                    us_d    = us_q + 10'sd1;
                    durum_d = YUVARLA;
                end else if (mb_q[26]) begin
                    durum_d = YUVARLA;
                end else begin
                    mb_d = {mb_q[26:0], 1'b0};
                    us_d = us_q - 10'sd1;
                end
            end

            YUVARLA: begin
`ifdef FP_TOPLAMA_YUVARLAMA_EN
                if (yuv_m[27]) begin
                    mb_d = {1'b0, yuv_m[27:2], yuv_m[1] | yuv_m[0]};
                    us_d = us_q + 10'sd1;
                end else begin
                    mb_d = yuv_m;
                end
`endif
                durum_d = PAKETLE;
            end

            PAKETLE: begin
                if (atla_q) begin
                    sonuc_d = a_q;
                end else if (us_q >= 10'sd255) begin
                    sonuc_d = {isaret_q, 8'hFF, 23'd0};
                end else if (us_q <= 10'sd0) begin
                    sonuc_d = 32'd0;
                end else begin
                    sonuc_d = {isaret_q, us_q[7:0], mb_q[25:3]};
                end
                gecerli_d = 1'b1;
                durum_d   = BOSTA;
            end

            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

endmodule

// File: tb/tb_fp_toplama.sv
// tb_fp_toplama: directed scoreboard bench for fp_toplama.
// Expected results and latencies are queued at acceptance, checked on each pulse.
module tb_fp_toplama;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        gec_i = 1'b0;
    logic [31:0] x1 = 32'd0;
    logic [31:0] x2 = 32'd0;
    logic        hazir;
    logic [31:0] sonuc;
    logic        gec_o;

    fp_toplama dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .gecerli_i (gec_i),
        .x1_i      (x1),
        .x2_i      (x2),
        .hazir_o   (hazir),
        .sonuc_o   (sonuc),
        .gecerli_o (gec_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] deger;
        int          kabul;
        int          gecikme;
        string       ad;
    } bekl_t;

    bekl_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_pulse = 0;

    task automatic kontrol(string ad, logic [31:0] gozlenen, logic [31:0] beklenen);
        n_chk++;
        assert (gozlenen === beklenen) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", ad, gozlenen, beklenen);
        end
    endtask

    always @(posedge clk) begin : izle
        bekl_t e;
        #1;
        if (gec_o === 1'b1) begin
            n_pulse++;
            if (q.size() == 0) begin
                kontrol("extra_pulse", {31'd0, gec_o}, 32'd0);
            end else begin
                e = q.pop_front();
                kontrol({e.ad, "_val"}, sonuc, e.deger);
                kontrol({e.ad, "_lat"}, 32'(cyc - e.kabul), 32'(e.gecikme));
            end
        end
    end

    task automatic gonder(string ad, logic [31:0] a, logic [31:0] b,
                          logic [31:0] e, int lat, bit tut);
        int t = 0;
        @(negedge clk);
        while (hazir !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (hazir !== 1'b1) kontrol({ad, "_ready"}, {31'd0, hazir}, 32'd1);
        x1    = a;
        x2    = b;
        gec_i = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{e, cyc, lat, ad});
        if (!tut) gec_i = 1'b0;
    endtask

    task automatic bekle();
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #2;
        kontrol("drain", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        int p0;
        logic [31:0] tie_exp;
`ifdef FP_TOPLAMA_YUVARLAMA_EN
        tie_exp = 32'h3F800002;
`else
        tie_exp = 32'h3F800001;
`endif
        #2 rst_n = 1'b0;
        #1;
        kontrol("rst_sonuc", sonuc, 32'd0);
        kontrol("rst_gec", {31'd0, gec_o}, 32'd0);
        kontrol("rst_hazir", {31'd0, hazir}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        gonder("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 5, 0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            kontrol("busy_hazir", {31'd0, hazir}, 32'd0);
        end
        bekle();

        gonder("three_half", 32'h40400000, 32'h3F000000, 32'h40600000, 7, 0);
        bekle();
        gonder("half_three", 32'h3F000000, 32'h40400000, 32'h40600000, 7, 0);
        bekle();
        gonder("cancel", 32'h3FC00000, 32'hBFC00000, 32'h00000000, 3, 0);
        bekle();
        gonder("three_m1", 32'h40400000, 32'hBF800000, 32'h40000000, 6, 0);
        bekle();
        gonder("m3_p1", 32'hC0400000, 32'h3F800000, 32'hC0000000, 6, 0);
        bekle();
        gonder("zero_pi", 32'h00000000, 32'h40490FDB, 32'h40490FDB, 2, 0);
        bekle();
        gonder("pi_zero", 32'h40490FDB, 32'h00000000, 32'h40490FDB, 2, 0);
        bekle();
        gonder("nz_nz", 32'h80000000, 32'h80000000, 32'h80000000, 2, 0);
        bekle();
        gonder("nz_pz", 32'h80000000, 32'h00000000, 32'h00000000, 2, 0);
        bekle();
        gonder("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5, 0);
        bekle();
        gonder("tie_d24", 32'h3F800001, 32'h33800000, tie_exp, 29, 0);
        bekle();
        gonder("norm_l2", 32'h3FC00000, 32'hBFA00000, 32'h3E800000, 7, 0);
        bekle();
        gonder("d_sat27", 32'h3F800000, 32'h2F800000, 32'h3F800000, 32, 0);
        bekle();
        gonder("underflow", 32'h00800001, 32'h80800000, 32'h00000000, 28, 0);
        bekle();

        p0 = n_pulse;
        gonder("hold_busy", 32'h3F800000, 32'h3F800000, 32'h40000000, 5, 1);
        repeat (4) @(posedge clk);
        #1;
        gec_i = 1'b0;
        bekle();
        repeat (10) @(posedge clk);
        #1;
        kontrol("hold_pulses", 32'(n_pulse - p0), 32'd1);

        gonder("abort", 32'h3F800001, 32'h33800000, tie_exp, 29, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        kontrol("abort_sonuc", sonuc, 32'd0);
        kontrol("abort_gec", {31'd0, gec_o}, 32'd0);
        kontrol("abort_hazir", {31'd0, hazir}, 32'd1);
        q.delete();
        p0 = n_pulse;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        kontrol("abort_nopulse", 32'(n_pulse - p0), 32'd0);

        gonder("after_rst", 32'h40400000, 32'h3F000000, 32'h40600000, 7, 0);
        bekle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_toplama.md
# fp_toplama

Multi-cycle IEEE-754 single-precision adder/subtractor in the floating-point datapath. It sits directly downstream of the multiplier and consumes its 32-bit product as one addend, e.g. for product accumulation. Alignment and normalization are bit-serial, one shift per clock, matching the multiplier's area-over-speed style. A valid/ready handshake replaces the multiplier's level enable.

## Interface
- No parameters.
- `clk_i` input, 1 bit: clock; all state changes on the rising edge.
- `rst_ni` input, 1 bit: asynchronous, active-low reset.
- `gecerli_i` input, 1 bit: operands valid; accepted only on an edge where `hazir_o`=1.
- `x1_i` input, 32 bits: operand A, IEEE-754 single.
- `x2_i` input, 32 bits: operand B, IEEE-754 single.
- `hazir_o` output, 1 bit: ready; high only in BOSTA.
- `sonuc_o` output, 32 bits: result; holds its value until the next result.
- `gecerli_o` output, 1 bit: one-cycle pulse when `sonuc_o` updates.

## Operation
- **Reset values:** `sonuc_o`=0, `gecerli_o`=0, `hazir_o`=1, state BOSTA. Reset asserted mid-operation aborts it and produces no pulse.
- **States:** BOSTA → AYIR → HIZALA → TOPLA → NORMAL → YUVARLA → PAKETLE → BOSTA.
- **BOSTA:** on `gecerli_i`=1, register both operands and go to AYIR. While busy, `gecerli_i` is ignored and nothing is queued.
- **AYIR:**
  - A field of exp==0 is treated as zero; denormals are flushed.
  - If either operand is zero: result = the other operand, go directly to PAKETLE. Two zeros give +0, or -0 only if both are -0.
  - Otherwise, order operands so that L has the larger magnitude (exponent, then mantissa) and S the other.
  - d = expL − expS.
- **Working mantissa, 28 bits:** [27] carry, [26] hidden 1, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- **Exponent:** held in a 10-bit signed register.
- **HIZALA:**
  - S is shifted right 1 bit per cycle, for min(d,27) cycles.
  - Bits shifted out are ORed into sticky.
  - Skipped when d=0.
- **TOPLA:**
  - Equal signs: mL+mS.
  - Opposite signs: mL−mS.
  - Result sign is the sign of L.
  - A zero difference gives +0 and goes to PAKETLE.
- **NORMAL:**
  - If carry is set: shift right 1 (sticky preserved), exp+1, in a single cycle.
  - Otherwise: one cycle of check, plus one left shift and exp−1 per cycle until bit 26=1. L denotes that number of left shifts.
- **YUVARLA:** behaviour is set by the macro in Configuration. This state is always present, so latency does not depend on the macro.
- **PAKETLE:**
  - exp ≥ 255 → {sign, 8'hFF, 23'h0}.
  - exp ≤ 0 → +0.
  - Otherwise → {sign, exp[7:0], m[25:3]}.
  - Register the result to `sonuc_o`, pulse `gecerli_o`, return to BOSTA.
- **Special values:** exp==255 inputs are not special-cased; they are processed as finite values. There is no NaN handling.

## Timing
- Take the accepting edge as edge 0.
- **Normal path:** `sonuc_o` and `gecerli_o` update on edge 5+min(d,27)+L.
- **Zero-operand shortcut:** update on edge 2.
- **Exact cancellation:** update on edge 3.
- `hazir_o` returns high on the same edge as the `gecerli_o` pulse. A new operand pair may be accepted on the following edge.
- `gecerli_o` is high for exactly one cycle per accepted operation.

## Configuration
- `FP_TOPLAMA_YUVARLAMA_EN` defined: YUVARLA performs round-to-nearest-even using guard/round/sticky.
  - If the increment carries into bit 27, shift right 1 and exp+1 within the same cycle.
- Undefined: YUVARLA is a one-cycle pass-through and the result is truncated. This matches the multiplier's rounding.

## Test plan
- 0x3F800000 + 0x3F800000 (d=0, carry) → 0x40000000, `gecerli_o` on edge 5, `hazir_o` low on edges 1–4.
- 0x40400000 + 0x3F000000 (3.0 + 0.5, d=2) → 0x40600000 on edge 7. The swapped operand order gives the same result and latency.
- 0x3FC00000 + 0xBFC00000 → 0x00000000 on edge 3. Also 0x40400000 + 0xBF800000 → 0x40000000.
- 0x00000000 + 0x40490FDB → 0x40490FDB on edge 2. Also 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
- 0x3F800001 + 0x33800000 (d=24, tie case):
  - With `FP_TOPLAMA_YUVARLAMA_EN` → 0x3F800002.
  - Without → 0x3F800001.
  - Both on edge 29.
- Mid-operation cases:
  - Deassert `rst_ni` during HIZALA → outputs reset immediately (asynchronously); no pulse.
  - `gecerli_i` held high while busy → exactly one result per accepted operand pair.
